// File: rtl/router_src_pkt_gen.sv
// Packet source engine for the router source port: serialises accepted requests
// into header, payload and parity bytes, then watches for router errors in a gap.
module router_src_pkt_gen #(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 2,
    parameter int               NUM_DEST  = 3,
    parameter int               GAP_CYC   = 2,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0]        req_seed,
    input  logic                     req_mode,
    input  logic                     req_bad_par,
    output logic                     pkt_valid,
    output logic [DATA_W-1:0]        data_out,
    input  logic                     busy,
    input  logic                     error,
    output logic                     reject,
    output logic                     done,
    output logic                     err_flag,
    input  logic                     clr_err,
    output logic [15:0]              pkt_count
);

    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int GAP_W = $clog2(GAP_CYC + 1) + 1;
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  ZERO_L = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  ZERO_G = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]  ONE_G  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  LOAD_G = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] next_byte(input logic [DATA_W-1:0] prev,
                                                    input logic lfsr);
        logic [DATA_W-1:0] shifted;
        shifted = {1'b0, prev[DATA_W-1:1]};
        if (!lfsr) begin
            return prev + ONE_D;
        end else if (prev[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

    function automatic logic [DATA_W-1:0] parity_fold(input logic [DATA_W-1:0] acc,
                                                      input logic [DATA_W-1:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [DATA_W-1:0] parity_out(input logic [DATA_W-1:0] acc,
                                                     input logic invert);
        return invert ? ~acc : acc;
    endfunction

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                valid_r, valid_s;
    logic                ready_r, ready_s;
    logic                reject_r, reject_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic [15:0]         count_r, count_s;
    logic [DATA_W-1:0]   cur_r, cur_s;
    logic [LEN_W-1:0]    remain_r, remain_s;
    logic [DATA_W-1:0]   par_r, par_s;
    logic [GAP_W-1:0]    gap_r, gap_s;
    logic                mode_r, mode_s;
    logic                bad_r, bad_s;
    logic                invalid_s;
    logic [DATA_W-1:0]   header_s;
    logic [DATA_W-1:0]   seed_s;

    assign req_ready = ready_r;
    assign pkt_valid = valid_r;
    assign data_out  = data_r;
    assign reject    = reject_r;
    assign done      = done_r;
    assign err_flag  = err_r;
    assign pkt_count = count_r;

    // Next-state and next-output logic for the serialiser.
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        valid_s   = valid_r;
        ready_s   = ready_r;
        reject_s  = 1'b0;
        done_s    = 1'b0;
        count_s   = count_r;
        cur_s     = cur_r;
        remain_s  = remain_r;
        par_s     = par_r;
        gap_s     = gap_r;
        mode_s    = mode_r;
        bad_s     = bad_r;
        invalid_s = (int'(req_addr) >= NUM_DEST) || (req_len == ZERO_L);
        header_s  = {req_len, req_addr};
        // A zero seed would lock the LFSR, so it is nudged to 1 in that mode only.
        seed_s    = (req_mode && (req_seed == ZERO_D)) ? ONE_D : req_seed;

        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                valid_s = 1'b0;
                data_s  = ZERO_D;
                if (req_valid && ready_r) begin
                    if (invalid_s) begin
                        reject_s = 1'b1;
                    end else begin
                        state_s  = ST_HEADER;
                        ready_s  = 1'b0;
                        valid_s  = 1'b1;
                        data_s   = header_s;
                        par_s    = header_s;
                        cur_s    = seed_s;
                        remain_s = req_len;
                        mode_s   = req_mode;
                        bad_s    = req_bad_par;
                    end
                end else begin
                    reject_s = 1'b0;
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (busy) begin
                    state_s = state_r;
                end else if (state_r == ST_PAYLOAD && remain_r == ZERO_L) begin
                    state_s = ST_PARITY;
                    valid_s = 1'b0;
                    data_s  = parity_out(par_r, bad_r);
                end else begin
                    state_s  = ST_PAYLOAD;
                    data_s   = cur_r;
                    par_s    = parity_fold(par_r, cur_r);
                    cur_s    = next_byte(cur_r, mode_r);
                    remain_s = remain_r - ONE_L;
                end
            end
            ST_PARITY: begin
                if (busy) begin
                    state_s = state_r;
                end else begin
                    state_s = ST_GAP;
                    data_s  = ZERO_D;
                    gap_s   = LOAD_G;
                    if (GAP_CYC == 1) begin
                        done_s  = 1'b1;
                        count_s = count_r + 16'd1;
                    end else begin
                        done_s = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                // Gap ignores busy; done lands on the final gap cycle.
                if (gap_r == ZERO_G) begin
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                end else begin
                    gap_s = gap_r - ONE_G;
                    if (gap_r == ONE_G) begin
                        done_s  = 1'b1;
                        count_s = count_r + 16'd1;
                    end else begin
                        done_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                data_s  = ZERO_D;
                ready_s = 1'b0;
            end
        endcase

        if (state_r == ST_GAP && error) begin
            err_s = 1'b1;
        end else if (clr_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            data_r   <= ZERO_D;
            valid_r  <= 1'b0;
            ready_r  <= 1'b0;
            reject_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            count_r  <= 16'd0;
            cur_r    <= ZERO_D;
            remain_r <= ZERO_L;
            par_r    <= ZERO_D;
            gap_r    <= ZERO_G;
            mode_r   <= 1'b0;
            bad_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            data_r   <= data_s;
            valid_r  <= valid_s;
            ready_r  <= ready_s;
            reject_r <= reject_s;
            done_r   <= done_s;
            err_r    <= err_s;
            count_r  <= count_s;
            cur_r    <= cur_s;
            remain_r <= remain_s;
            par_r    <= par_s;
            gap_r    <= gap_s;
            mode_r   <= mode_s;
            bad_r    <= bad_s;
        end
    end

endmodule

// File: tb/tb_router_src_pkt_gen.sv
// Self-checking bench for router_src_pkt_gen: directed scenarios plus randomized
// requests compared against a byte-list reference model.
module tb_router_src_pkt_gen;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int ND = 3;
    localparam int GC = 2;
    localparam logic [7:0] TAPS = 8'hB8;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_addr = 2'd0;
    logic [5:0] req_len = 6'd0;
    logic [7:0] req_seed = 8'd0;
    logic       req_mode = 1'b0;
    logic       req_bad_par = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy = 1'b0;
    logic       error = 1'b0;
    logic       reject;
    logic       done;
    logic       err_flag;
    logic       clr_err = 1'b0;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int model_count = 0;
    logic model_err = 1'b0;
    logic [7:0] exp_q[$];

    router_src_pkt_gen #(.DATA_W(DW), .ADDR_W(AW), .NUM_DEST(ND), .GAP_CYC(GC),
                         .LFSR_TAPS(TAPS)) dut (
        .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_seed(req_seed),
        .req_mode(req_mode), .req_bad_par(req_bad_par), .pkt_valid(pkt_valid),
        .data_out(data_out), .busy(busy), .error(error), .reject(reject),
        .done(done), .err_flag(err_flag), .clr_err(clr_err), .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected transmitted bytes: header, payload, parity.
    task automatic build(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] seed,
                         input logic mode, input logic bad);
        logic [7:0] v;
        logic [7:0] b;
        logic [7:0] acc;
        exp_q.delete();
        acc = {len, addr};
        exp_q.push_back(acc);
        v = (mode && seed == 8'd0) ? 8'd1 : seed;
        for (int k = 0; k < int'(len); k++) begin
            if (!mode) begin
                b = 8'((int'(seed) + k) % 256);
            end else begin
                b = v;
                v = (v & 8'd1) != 8'd0 ? ((v >> 1) ^ TAPS) : (v >> 1);
            end
            exp_q.push_back(b);
            acc = acc ^ b;
        end
        exp_q.push_back(bad ? ~acc : acc);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] seed,
                         input logic mode, input logic bad);
        wait_ready();
        req_addr = addr; req_len = len; req_seed = seed; req_mode = mode; req_bad_par = bad;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        req_seed = 8'($urandom);
    endtask

    task automatic send(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] seed,
                        input logic mode, input logic bad, input int busy_pct,
                        input int stall_idx, input int stall_n, input bit err_g, input bit clr_g);
        int i;
        int stalls;
        int guard;
        logic b;
        build(addr, len, seed, mode, bad);
        issue(addr, len, seed, mode, bad);
        i = 0; stalls = 0; guard = 0;
        while (i < exp_q.size() && guard < 3000) begin
            check("byte", 32'(data_out), 32'(exp_q[i]));
            check("pkt_valid", 32'(pkt_valid), 32'(i < exp_q.size() - 1));
            check("ready_busy", 32'(req_ready), 32'd0);
            check("done_early", 32'(done), 32'd0);
            b = (i == stall_idx && stalls < stall_n) || (int'($urandom_range(99)) < busy_pct);
            if (b && i == stall_idx) stalls++;
            busy = b;
            @(negedge clock);
            if (!b) i++;
            guard++;
        end
        if (guard >= 3000) check("stream_timeout", 32'(i), 32'(exp_q.size()));
        for (int g = 1; g <= GC; g++) begin
            if (g == GC) model_count = (model_count + 1) % 65536;
            check("gap_data", 32'(data_out), 32'd0);
            check("gap_valid", 32'(pkt_valid), 32'd0);
            check("gap_done", 32'(done), 32'(g == GC));
            check("gap_count", 32'(pkt_count), 32'(model_count));
            error = err_g && g == 1;
            clr_err = clr_g && g == 1;
            busy = 1'($urandom_range(1));
            if (error) model_err = 1'b1;
            else if (clr_err) model_err = 1'b0;
            @(negedge clock);
            error = 1'b0; clr_err = 1'b0;
            check("err_flag", 32'(err_flag), 32'(model_err));
        end
        busy = 1'b0;
        check("ready_after", 32'(req_ready), 32'd1);
        check("done_after", 32'(done), 32'd0);
        check("count_after", 32'(pkt_count), 32'(model_count));
    endtask

    task automatic rejected(input logic [1:0] addr, input logic [5:0] len);
        issue(addr, len, 8'($urandom), 1'($urandom_range(1)), 1'b0);
        check("reject_pulse", 32'(reject), 32'd1);
        check("reject_valid", 32'(pkt_valid), 32'd0);
        @(negedge clock);
        check("reject_end", 32'(reject), 32'd0);
        check("reject_valid2", 32'(pkt_valid), 32'd0);
        check("reject_count", 32'(pkt_count), 32'(model_count));
        check("reject_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] ra;
        logic [5:0] rl;
        int i;

        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_flag), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;
        @(negedge clock);
        check("ready_rise", 32'(req_ready), 32'd1);

        send(2'd1, 6'd4, 8'h10, 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b0);
        send(2'd1, 6'd4, 8'h10, 1'b0, 1'b0, 0, 3, 3, 1'b0, 1'b0);
        rejected(2'd3, 6'd5);
        rejected(2'd1, 6'd0);
        send(2'd0, 6'd1, 8'h00, 1'b0, 1'b1, 0, -1, 0, 1'b1, 1'b0);
        clr_err = 1'b1; model_err = 1'b0;
        @(negedge clock);
        clr_err = 1'b0;
        check("clr_err", 32'(err_flag), 32'd0);
        send(2'd2, 6'd3, 8'h00, 1'b1, 1'b0, 0, -1, 0, 1'b0, 1'b0);
        send(2'd1, 6'd2, 8'h7F, 1'b1, 1'b0, 0, -1, 0, 1'b1, 1'b1);

        // Reset while payload byte 2 of a length-6 packet is on the bus.
        build(2'd2, 6'd6, 8'hF0, 1'b0, 1'b0);
        issue(2'd2, 6'd6, 8'hF0, 1'b0, 1'b0);
        for (i = 0; i < 3; i++) @(negedge clock);
        check("pre_rst_byte", 32'(data_out), 32'(exp_q[3]));
        rst = 1'b1;
        #1;
        model_count = 0; model_err = 1'b0;
        check("arst_valid", 32'(pkt_valid), 32'd0);
        check("arst_data", 32'(data_out), 32'd0);
        check("arst_count", 32'(pkt_count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_done2", 32'(done), 32'd0);

        for (int r = 0; r < 40; r++) begin
            ra = 2'($urandom_range(3));
            rl = ($urandom_range(9) == 0) ? 6'd63 : 6'($urandom_range(9));
            if (int'(ra) >= ND || rl == 6'd0) begin
                rejected(ra, rl);
            end else begin
                send(ra, rl, 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     25, -1, 0, ($urandom_range(3) == 0), ($urandom_range(3) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
